// File: rtl/sad_luma16x16_if.sv
// Streaming row/result bundle for the 16x16 luma SAD engine.
// The master drives macroblock rows; the slave (the engine) returns SADs and residue buffers.
`timescale 1ns/1ps
interface sad_luma16x16_if #(parameter int SAD_WIDTH = 16);
  logic                 start_i;
  logic [8:0]           mbnumber_i;
  logic                 row_valid_i;
  logic [7:0]           orig_i  [16];
  logic [7:0]           vpred_i [16];
  logic [7:0]           hpred_i;
  logic [7:0]           dcpred_i;
  logic                 busy_o;
  logic                 done_o;
  logic [SAD_WIDTH-1:0] sads_o  [3];
  logic [7:0]           vres_o  [256];
  logic [7:0]           hres_o  [256];
  logic [7:0]           dcres_o [256];
  logic [8:0]           mbnumber_o;

  modport master (
    output start_i, mbnumber_i, row_valid_i, orig_i, vpred_i, hpred_i, dcpred_i,
    input  busy_o, done_o, sads_o, vres_o, hres_o, dcres_o, mbnumber_o
  );

  modport slave (
    input  start_i, mbnumber_i, row_valid_i, orig_i, vpred_i, hpred_i, dcpred_i,
    output busy_o, done_o, sads_o, vres_o, hres_o, dcres_o, mbnumber_o
  );
endinterface

// File: rtl/sad_luma16x16.sv
// Intra 16x16 luma SAD/residue engine: V, H and DC residues per row, three SADs
// accumulated over 16 rows, handed off with a one-cycle done pulse.
`timescale 1ns/1ps
module sad_luma16x16 #(
  parameter int SAD_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  sad_luma16x16_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam int AW = ((SAD_WIDTH > 12) ? SAD_WIDTH : 12) + 1;

  state_t               state_q;
  logic [3:0]           rowcnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [8:0]           mbn_q;
  logic [SAD_WIDTH-1:0] acc_q [3];

  logic                 v1_q;
  logic [3:0]           row1_q;
  logic                 v2_q;

  logic [7:0]           abs_d [3][16];
  logic [7:0]           res_d [3][16];
  logic [7:0]           abs_q [3][16];
  logic [7:0]           res_q [3][16];
  logic [11:0]          sum_d [3];
  logic [11:0]          sum_q [3];

  logic [7:0]           vres_q  [256];
  logic [7:0]           hres_q  [256];
  logic [7:0]           dcres_q [256];

  logic                 accept;
  logic                 start_ok;

  assign accept   = (state_q == ACCUM) && bus.row_valid_i;
  // The done cycle itself sits in IDLE, so start is masked there too.
  assign start_ok = (state_q == IDLE) && bus.start_i && !done_q;

  function automatic logic [SAD_WIDTH-1:0] sat_add(logic [SAD_WIDTH-1:0] a, logic [11:0] b);
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    if (s > AW'({SAD_WIDTH{1'b1}})) return '1;
    return s[SAD_WIDTH-1:0];
  endfunction

  genvar gm, gi;
  generate
    for (gm = 0; gm < 3; gm++) begin : g_mode
      for (gi = 0; gi < 16; gi++) begin : g_col
        logic [7:0]        pred;
        logic signed [8:0] d;
        if (gm == 0) begin : g_v
          assign pred = bus.vpred_i[gi];
        end else if (gm == 1) begin : g_h
          assign pred = bus.hpred_i;
        end else begin : g_dc
          assign pred = bus.dcpred_i;
        end
        assign d = $signed({1'b0, bus.orig_i[gi]}) - $signed({1'b0, pred});
        assign abs_d[gm][gi] = d[8] ? 8'(-d) : d[7:0];
        assign res_d[gm][gi] = (d > 9'sd127)  ? 8'h7F :
                               (d < -9'sd128) ? 8'h80 : d[7:0];
      end
    end
  endgenerate

  always_comb begin
    for (int m = 0; m < 3; m++) begin
      sum_d[m] = '0;
      for (int c = 0; c < 16; c++) begin
        sum_d[m] = sum_d[m] + 12'(abs_q[m][c]);
      end
    end
  end

  // Datapath registers carry no reset; their valids below do.
  always_ff @(posedge clk) begin
    if (accept) begin
      abs_q <= abs_d;
      res_q <= res_d;
    end
    sum_q <= sum_d;
    if (v1_q) begin
      for (int c = 0; c < 16; c++) begin
        vres_q [{row1_q, 4'(c)}] <= res_q[0][c];
        hres_q [{row1_q, 4'(c)}] <= res_q[1][c];
        dcres_q[{row1_q, 4'(c)}] <= res_q[2][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rowcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mbn_q    <= '0;
      v1_q     <= 1'b0;
      row1_q   <= '0;
      v2_q     <= 1'b0;
      for (int m = 0; m < 3; m++) acc_q[m] <= '0;
    end else begin
      done_q <= 1'b0;
      v1_q   <= accept;
      v2_q   <= v1_q;
      if (accept) row1_q <= rowcnt_q;
      if (v2_q) begin
        for (int m = 0; m < 3; m++) acc_q[m] <= sat_add(acc_q[m], sum_q[m]);
      end
      if (done_q) busy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q  <= ACCUM;
            busy_q   <= 1'b1;
            rowcnt_q <= '0;
            mbn_q    <= bus.mbnumber_i;
            for (int m = 0; m < 3; m++) acc_q[m] <= '0;
          end
        end
        ACCUM: begin
          if (bus.row_valid_i) begin
            if (rowcnt_q == 4'd15) state_q <= DRAIN;
            else                   rowcnt_q <= rowcnt_q + 4'd1;
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.sads_o     = acc_q;
  assign bus.mbnumber_o = mbn_q;
  assign bus.vres_o     = vres_q;
  assign bus.hres_o     = hres_q;
  assign bus.dcres_o    = dcres_q;
endmodule

// File: tb/tb_sad_luma16x16.sv
// Self-checking bench for sad_luma16x16: table of blocks, scoreboard of SADs,
// plus hand-written protocol and mid-block reset sequences.
`timescale 1ns/1ps
module tb_sad_luma16x16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_luma16x16_if #(.SAD_WIDTH(16)) sif ();
  sad_luma16x16 #(.SAD_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(sif));

  typedef struct {
    int kind;       // 0 flat, 1 ramp, 2 random
    int o, v, h, dc;
    int mbn;
    int stall_a, stall_b, gap;
    bit glitch;
    bit use_model;
    int e0, e1, e2;
  } vec_t;

  typedef struct packed {
    logic [15:0] s0, s1, s2;
    logic [8:0]  mbn;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[7];

  logic [7:0] blk_o [256];
  logic [7:0] blk_v [16];
  logic [7:0] blk_h [16];
  logic [7:0] blk_dc;
  logic [7:0] exp_vr[256], exp_hr[256], exp_dr[256];

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  function automatic logic [7:0] clamp8(int d);
    logic [31:0] t;
    if (d > 127)  return 8'h7F;
    if (d < -128) return 8'h80;
    t = d;
    return t[7:0];
  endfunction

  function automatic int iabs(int d);
    return (d < 0) ? -d : d;
  endfunction

  task automatic build(vec_t v);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (v.kind)
          0:       blk_o[r*16+c] = 8'(v.o);
          1:       blk_o[r*16+c] = 8'(16*r + c);
          default: blk_o[r*16+c] = 8'($urandom_range(0, 255));
        endcase
      end
      case (v.kind)
        0:       begin blk_v[r] = 8'(v.v); blk_h[r] = 8'(v.h); end
        1:       begin blk_v[r] = 8'(r);   blk_h[r] = 8'(16*r); end
        default: begin blk_v[r] = 8'($urandom_range(0, 255)); blk_h[r] = 8'($urandom_range(0, 255)); end
      endcase
    end
    case (v.kind)
      0:       blk_dc = 8'(v.dc);
      1:       blk_dc = 8'd128;
      default: blk_dc = 8'($urandom_range(0, 255));
    endcase
  endtask

  task automatic model_push(vec_t v);
    int sv, sh, sd, dv, dh, dd;
    exp_t e;
    sv = 0; sh = 0; sd = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        dv = int'(blk_o[r*16+c]) - int'(blk_v[c]);
        dh = int'(blk_o[r*16+c]) - int'(blk_h[r]);
        dd = int'(blk_o[r*16+c]) - int'(blk_dc);
        sv += iabs(dv); sh += iabs(dh); sd += iabs(dd);
        exp_vr[r*16+c] = clamp8(dv);
        exp_hr[r*16+c] = clamp8(dh);
        exp_dr[r*16+c] = clamp8(dd);
      end
    end
    if (!v.use_model) begin
      sv = v.e0; sh = v.e1; sd = v.e2;
    end
    e.s0 = 16'(sv); e.s1 = 16'(sh); e.s2 = 16'(sd); e.mbn = 9'(v.mbn);
    sb.push_back(e);
  endtask

  task automatic drive_row(int r);
    sif.row_valid_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sif.orig_i[c]  = blk_o[r*16+c];
      sif.vpred_i[c] = blk_v[c];
    end
    sif.hpred_i  = blk_h[r];
    sif.dcpred_i = blk_dc;
  endtask

  task automatic check_residues(string tag);
    int iv, ih, id;
    iv = 0; ih = 0; id = 0;
    for (int i = 255; i >= 0; i--) begin
      if (sif.vres_o[i]  !== exp_vr[i]) iv = i;
      if (sif.hres_o[i]  !== exp_hr[i]) ih = i;
      if (sif.dcres_o[i] !== exp_dr[i]) id = i;
    end
    check({tag, " vres"},  32'(sif.vres_o[iv]),  32'(exp_vr[iv]));
    check({tag, " hres"},  32'(sif.hres_o[ih]),  32'(exp_hr[ih]));
    check({tag, " dcres"}, 32'(sif.dcres_o[id]), 32'(exp_dr[id]));
  endtask

  task automatic run_block(vec_t v, string tag);
    int   cyc, guard, stalls, extra_done, busy_seen;
    exp_t e;
    build(v);
    @(negedge clk);
    sif.start_i    = 1'b1;
    sif.mbnumber_i = 9'(v.mbn);
    model_push(v);
    cyc = 0; stalls = 0;
    @(negedge clk); cyc++;
    sif.start_i = 1'b0;
    check({tag, " busy_after_start"}, 32'(sif.busy_o), 32'd1);
    for (int r = 0; r < 16; r++) begin
      drive_row(r);
      if (v.glitch && r == 7) begin
        sif.start_i    = 1'b1;
        sif.mbnumber_i = 9'd99;
      end
      @(negedge clk); cyc++;
      sif.start_i     = 1'b0;
      sif.row_valid_i = 1'b0;
      if (r == v.stall_a || r == v.stall_b) begin
        for (int c = 0; c < 16; c++) sif.orig_i[c] = 8'($urandom_range(0, 255));
        sif.hpred_i = 8'($urandom_range(0, 255));
        repeat (v.gap) begin @(negedge clk); cyc++; end
        stalls++;
      end
    end
    guard = 0;
    while (!sif.done_o && guard < 40) begin
      @(negedge clk); cyc++; guard++;
    end
    if (guard >= 40) begin
      check({tag, " done_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    check({tag, " block_cycles"}, 32'(cyc), 32'(19 + stalls * v.gap));
    e = sb.pop_front();
    check({tag, " sad_v"},    32'(sif.sads_o[0]),  32'(e.s0));
    check({tag, " sad_h"},    32'(sif.sads_o[1]),  32'(e.s1));
    check({tag, " sad_dc"},   32'(sif.sads_o[2]),  32'(e.s2));
    check({tag, " mbnumber"}, 32'(sif.mbnumber_o), 32'(e.mbn));
    check({tag, " busy_in_done"}, 32'(sif.busy_o), 32'd1);
    check_residues(tag);
    if (v.glitch) begin
      sif.start_i    = 1'b1;
      sif.mbnumber_i = 9'd77;
    end
    @(negedge clk);
    sif.start_i = 1'b0;
    check({tag, " done_one_cycle"}, 32'(sif.done_o), 32'd0);
    check({tag, " busy_after_done"}, 32'(sif.busy_o), 32'd0);
    if (v.glitch) begin
      extra_done = 0; busy_seen = 0;
      repeat (25) begin
        @(negedge clk);
        if (sif.done_o) extra_done++;
        if (sif.busy_o) busy_seen++;
      end
      check({tag, " extra_done"}, 32'(extra_done), 32'd0);
      check({tag, " busy_idle"},  32'(busy_seen),  32'd0);
      check({tag, " sad_v_held"}, 32'(sif.sads_o[0]), 32'(e.s0));
      check({tag, " mbn_held"},   32'(sif.mbnumber_o), 32'(e.mbn));
    end
    $display("block %s: mbn=%0d sads=%0d/%0d/%0d cycles=%0d", tag, v.mbn,
             sif.sads_o[0], sif.sads_o[1], sif.sads_o[2], cyc);
  endtask

  initial begin
    int done_seen;
    tbl[0] = '{0, 100,  90, 110, 100,  37, -1, -1, 0, 1'b0, 1'b0,  2560,  2560,     0};
    tbl[1] = '{0, 255,   0,   0,   0,   5, -1, -1, 0, 1'b0, 1'b0, 65280, 65280, 65280};
    tbl[2] = '{0,   0, 255, 255, 255,   6, -1, -1, 0, 1'b0, 1'b0, 65280, 65280, 65280};
    tbl[3] = '{1,   0,   0,   0,   0, 100, -1, -1, 0, 1'b0, 1'b1,     0,     0,     0};
    tbl[4] = '{1,   0,   0,   0,   0, 100,  4, 11, 3, 1'b0, 1'b1,     0,     0,     0};
    tbl[5] = '{2,   0,   0,   0,   0, 511, -1, -1, 0, 1'b0, 1'b1,     0,     0,     0};
    tbl[6] = '{2,   0,   0,   0,   0, 200,  2, -1, 2, 1'b1, 1'b1,     0,     0,     0};

    rst = 1'b1;
    sif.start_i = 1'b0; sif.mbnumber_i = '0; sif.row_valid_i = 1'b0;
    sif.hpred_i = '0; sif.dcpred_i = '0;
    for (int c = 0; c < 16; c++) begin sif.orig_i[c] = '0; sif.vpred_i[c] = '0; end
    repeat (3) @(negedge clk);
    check("reset busy",  32'(sif.busy_o), 32'd0);
    check("reset done",  32'(sif.done_o), 32'd0);
    check("reset sad_v", 32'(sif.sads_o[0]), 32'd0);
    check("reset mbn",   32'(sif.mbnumber_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_block(tbl[i], $sformatf("vec%0d", i));

    // Mid-block reset: abort after row 8, then a full block.
    build(tbl[3]);
    @(negedge clk);
    sif.start_i = 1'b1; sif.mbnumber_i = 9'd300;
    model_push(tbl[3]);
    @(negedge clk);
    sif.start_i = 1'b0;
    for (int r = 0; r <= 8; r++) begin
      drive_row(r);
      @(negedge clk);
    end
    sif.row_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst busy",   32'(sif.busy_o), 32'd0);
    check("midrst done",   32'(sif.done_o), 32'd0);
    check("midrst sad_v",  32'(sif.sads_o[0]), 32'd0);
    check("midrst sad_dc", 32'(sif.sads_o[2]), 32'd0);
    check("midrst mbn",    32'(sif.mbnumber_o), 32'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (sif.done_o || sif.busy_o) done_seen++;
    end
    check("midrst no_done", 32'(done_seen), 32'd0);
    $display("block midrst: aborted after row 8");
    run_block(tbl[0], "post_rst");

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sad_luma16x16.md
# sad_luma16x16

Intra 16x16 luma SAD/residue engine. Streams one 16-pixel macroblock row per beat and forms residues against the vertical, horizontal and DC predictions. Accumulates the three per-mode SADs over the 16 rows and hands them, with the residue buffers and macroblock number, to the 16x16 mode saver via a one-cycle `done` pulse that drives the saver's `enable`.

## Interface
Parameters:
- `SAD_WIDTH`, 16: width of each accumulated SAD; 256·255 = 65280 fits without overflow.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: begin a macroblock; sampled only in IDLE.
- `mbnumber_in` input 9: macroblock index, latched on accepted `start`.
- `row_valid` input 1: current row beat is valid.
- `orig` input [7:0] ×16: original luma row, column 0..15.
- `vpred` input [7:0] ×16: vertical prediction (top-neighbour row, same every beat).
- `hpred` input 8: horizontal prediction for this row (left neighbour).
- `dcpred` input 8: DC prediction, constant across the block.
- `busy` output 1: high from accepted `start` until `done` cycle inclusive.
- `done` output 1: one-cycle pulse; `sads`/residues/`mbnumber` valid in that cycle and held until next `start`.
- `sads` output [SAD_WIDTH-1:0] ×3: index 0 = V, 1 = H, 2 = DC.
- `vres`, `hres`, `dcres` output [7:0] ×256: signed residues, index row·16+col.
- `mbnumber` output 9: latched macroblock number.

## Operation
- FSM states:
  - IDLE: `busy`=0; `start`=1 → ACCUM and clear accumulators, row counter and residue write pointer.
  - ACCUM: each cycle with `row_valid`=1 is accepted as row `rowcnt`. After row 15 is accepted → DRAIN.
  - DRAIN: one cycle for pipeline flush → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored, with no effect on the running block. `row_valid` outside ACCUM is ignored.
- Stage 1 (registered on accepted beat), per column c:
  - dV = orig−vpred[c], dH = orig−hpred, dDC = orig−dcpred, each 9-bit signed.
  - Register |d| (8 bits) and the saturated residue: clamp d to [−128, 127], store as 8-bit two's complement.
  - Residues are written into the `vres`/`hres`/`dcres` buffers at row·16+c.
- Stage 2: sum the 16 |d| per mode (12-bit adder tree) and add it into the SAD_WIDTH accumulator. No wrap is possible at the default width. If SAD_WIDTH is smaller, the accumulator saturates at all-ones.
- `rowcnt` is 4 bits. It increments only on accepted beats and does not wrap within a block; the 16th accept ends ACCUM.
- Output buffers and `sads` are overwritten only by the next block. Between blocks they hold their last values.

## Timing
- Row r accepted at edge E: its residues are visible at E+1, and its SAD contribution is in the accumulator at E+2.
- Row 15 accepted at edge E:
  - `done`=1 during the cycle after edge E+2.
  - `sads` final from edge E+2.
  - Latency from the last row to `done` is 2 cycles.
- Minimum block time: `start` cycle + 16 beats + 2 cycles. Back-to-back blocks need `start` on the cycle after `done`.
- Gaps in `row_valid` stall the row count only. Pipeline stages still advance, so the result is unaffected and `done` slips by the gap length.
- Reset values (asynchronous, immediate):
  - state IDLE, `busy`=0, `done`=0.
  - `sads`=0, `mbnumber`=0, `rowcnt`=0, all pipeline valids 0.
  - Residue buffers are not reset.
- Reset mid-block aborts with no `done`. A `start` after reset release begins cleanly.

## Test plan
- Flat block: orig=100, vpred=90, hpred=110, dcpred=100 for all rows, `mbnumber_in`=37 → `sads`={2560, 2560, 0}, all vres=10, hres=−10 (8'hF6), dcres=0, `mbnumber`=37, `done` exactly 2 cycles after the 16th beat.
- Saturation: orig=255, all preds=0 → residues 127 (8'h7F), `sads`={65280, 65280, 65280}. Then orig=0, preds=255 → residues −128 (8'h80), same SADs.
- Mixed rows: orig row r = 16·r + c, vpred[c]=c, hpred=16·r, dcpred=128 → each residue matches the reference model at index r·16+c; SADs match the model exactly.
- Stalls: drop `row_valid` for 3 cycles after rows 4 and 11 → identical outputs to the no-stall run, `done` 6 cycles later.
- Protocol: `start` pulsed during ACCUM and in the `done` cycle → ignored, one `done` only. `start` in IDLE after `done` runs the next block correctly.
- Reset: assert `reset` after row 8 → `busy`=0, `done`=0, `sads`=0 immediately, no `done` follows. A new full block then completes with correct values.
